// File: rtl/series_term_gen_if.sv
// Term interface between the series term generator (slave side, produces
// terms) and whoever launches sequences and consumes terms (master side).
interface series_term_gen_if;
  logic        start;
  logic [15:0] Xbus;
  logic [15:0] Tbus;
  logic        Done;
  logic        co;
  logic [2:0]  count;
  logic        busy;

  // Launching / consuming side.
  modport master (
    output start, Xbus,
    input  Tbus, Done, co, count, busy
  );

  // Term generator side.
  modport slave (
    input  start, Xbus,
    output Tbus, Done, co, count, busy
  );
endinterface

// File: rtl/series_term_gen.sv
// Taylor-series term generator: emits T1..T8 of x^n/n! (unsigned Q0.16),
// one term every 33 cycles, using a 16-step shift-add multiplier and a
// 16-step restoring divider.
// Optional build macro: SERIES_TERM_ROUND_EN selects round-to-nearest in
// both the multiply and the divide (default: truncation).
module series_term_gen (
  input logic              clk,
  input logic              rst,   // asynchronous, active-low
  series_term_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_MUL, S_DIV} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;        // captured operand
  logic [15:0] t_q, t_d;        // current term, drives Tbus directly
  logic [2:0]  cnt_q, cnt_d;    // index of the term in t_q
  logic [31:0] prod_q, prod_d;  // MUL: {hi, multiplier}; DIV: hi = dividend/quotient
  logic [3:0]  rem_q, rem_d;    // divider partial remainder (< d <= 8)
  logic [3:0]  step_q, step_d;  // 16-step counter shared by MUL and DIV
  logic        done_q, done_d;
  logic        co_q, co_d;
  logic        busy_q, busy_d;

  // Multiply step: add multiplicand to the high half when the multiplier
  // LSB is set, then shift the whole product right by one.
  logic [16:0] mul_sum;
  logic [31:0] mul_next;
  logic [15:0] mul_p;           // P taken from the finished product

  assign mul_sum  = {1'b0, prod_q[31:16]} + (prod_q[0] ? {1'b0, t_q} : 17'd0);
  assign mul_next = {mul_sum, prod_q[15:1]};

`ifdef SERIES_TERM_ROUND_EN
  logic [16:0] mul_rnd;
  // Adding 0x8000 before taking [31:16] is the same as adding bit 15 to the high half.
  assign mul_rnd = {1'b0, mul_next[31:16]} + {16'h0, mul_next[15]};
  assign mul_p   = mul_rnd[16] ? 16'hFFFF : mul_rnd[15:0];
`else
  assign mul_p   = mul_next[31:16];
`endif

  // Divide step: shift the dividend MSB into the remainder and subtract
  // the divisor when it fits; the quotient bit enters at the LSB.
  logic [3:0]  div_d;
  logic [4:0]  div_shift;
  logic        div_ge;
  logic [3:0]  div_diff;
  logic [3:0]  div_rem_next;
  logic [15:0] div_q_next;
  logic [15:0] div_result;

  assign div_d        = {1'b0, cnt_q} + 4'd2;
  assign div_shift    = {rem_q, prod_q[31]};
  assign div_ge       = (div_shift >= {1'b0, div_d});
  // When the divisor fits, the difference is below d, so four bits suffice.
  assign div_diff     = div_shift[3:0] - div_d;
  assign div_rem_next = div_ge ? div_diff : div_shift[3:0];
  assign div_q_next   = {prod_q[30:16], div_ge};

`ifdef SERIES_TERM_ROUND_EN
  logic        div_up;
  logic [16:0] div_rnd;
  assign div_up     = ({div_rem_next, 1'b0} >= {1'b0, div_d});
  assign div_rnd    = {1'b0, div_q_next} + {16'h0, div_up};
  assign div_result = div_rnd[16] ? 16'hFFFF : div_rnd[15:0];
`else
  assign div_result = div_q_next;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: EMIT -> 16 x MUL -> 16 x DIV -> EMIT, until term 8.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_EMIT;
      S_EMIT: state_d = (cnt_q == 3'd7) ? S_IDLE : S_MUL;
      S_MUL:  if (step_q == 4'd15) state_d = S_DIV;
      S_DIV:  if (step_q == 4'd15) state_d = S_EMIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; T and count change only on entry to EMIT.
  always_comb begin
    x_d    = x_q;
    t_d    = t_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    rem_d  = rem_q;
    step_d = step_q;
    done_d = 1'b0;
    co_d   = 1'b0;
    // Busy stays high through the final EMIT and drops one edge later.
    busy_d = (state_q != S_IDLE) || bus.start;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d   = bus.Xbus;
          t_d   = bus.Xbus;
          cnt_d = 3'd0;
        end
      end
      S_EMIT: begin
        done_d = 1'b1;
        co_d   = (cnt_q == 3'd7);
        prod_d = {16'h0, x_q};
        rem_d  = 4'd0;
        step_d = 4'd0;
      end
      S_MUL: begin
        prod_d = mul_next;
        step_d = step_q + 4'd1;
        rem_d  = 4'd0;
        if (step_q == 4'd15) prod_d[31:16] = mul_p;
      end
      S_DIV: begin
        prod_d = {div_q_next, prod_q[15:0]};
        rem_d  = div_rem_next;
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          t_d   = div_result;
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= 16'h0;
      t_q    <= 16'h0;
      cnt_q  <= 3'd0;
      prod_q <= 32'h0;
      rem_q  <= 4'd0;
      step_q <= 4'd0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      t_q    <= t_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      rem_q  <= rem_d;
      step_q <= step_d;
      done_q <= done_d;
      co_q   <= co_d;
      busy_q <= busy_d;
    end
  end

  assign bus.Tbus  = t_q;
  assign bus.count = cnt_q;
  assign bus.Done  = done_q;
  assign bus.co    = co_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_series_term_gen.sv
// Randomized scoreboard bench for series_term_gen: the driver predicts every
// term (value, index, co, arrival cycle) from the recurrence and queues it;
// the monitor checks each Done pulse and the busy window every cycle.
module tb_series_term_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  series_term_gen_if bus ();

  series_term_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] t;
    logic [2:0]  cnt;
    logic        co;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;     // value k after rising edge k
  int   last_k = -1000; // edge at which the latest sequence was accepted

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference recurrence: T_n = (T_{n-1} * x) / n with the selected rounding.
  function automatic logic [15:0] next_term(logic [15:0] t, logic [15:0] x, int n);
    longint p, q, r;
`ifdef SERIES_TERM_ROUND_EN
    p = (longint'(t) * longint'(x) + 64'h8000) >> 16;
    if (p > 65535) p = 65535;
    q = p / n;
    r = p % n;
    if (2 * r >= n) q = q + 1;
    if (q > 65535) q = 65535;
`else
    p = (longint'(t) * longint'(x)) >> 16;
    q = p / n;
`endif
    return q[15:0];
  endfunction

  // One stimulus cycle; predicts acceptance from the 233-cycle spacing rule.
  task automatic drive(bit s, logic [15:0] xb);
    int e;
    logic [15:0] t;
    @(negedge clk);
    bus.start = s;
    bus.Xbus  = xb;
    e = cyc + 1;
    if (s && rst && e >= last_k + 233) begin
      last_k = e;
      t = xb;
      for (int n = 1; n <= 8; n++) begin
        if (n > 1) t = next_term(t, xb, n);
        sb.push_back('{t: t, cnt: 3'(n - 1), co: (n == 8), cyc: e + 1 + 33 * (n - 1)});
      end
      $display("start accepted: x=0x%04h at edge %0d, T8 expected 0x%04h", xb, e, t);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
  endtask

  task automatic run_seq(logic [15:0] x);
    drive(1'b1, x);
    idle(240);
  endtask

  // Monitor: busy window every cycle, and each Done against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("busy", 32'(bus.busy), 32'(cyc >= last_k && cyc < last_k + 233));
      if (bus.Done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=1 Tbus=0x%04h, expected no Done (cycle %0d)",
                   bus.Tbus, cyc);
        end else begin
          e = sb.pop_front();
          check("tbus",     32'(bus.Tbus),  32'(e.t));
          check("count",    32'(bus.count), 32'(e.cnt));
          check("co",       32'(bus.co),    32'(e.co));
          check("done_cyc", 32'(cyc),       32'(e.cyc));
        end
      end else begin
        check("co_without_done", 32'(bus.co), 32'd0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_done: got Done=0, expected Done with count %0d (cycle %0d)",
                   e.cnt, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(string tag);
    check({tag, "_tbus"},  32'(bus.Tbus),  32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_done"},  32'(bus.Done),  32'd0);
    check({tag, "_co"},    32'(bus.co),    32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.Xbus  = 16'h0;
    #3 rst = 1'b0;
    #1 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed operands: half, all-ones (upper-half truncation), zero.
    run_seq(16'h8000);
    run_seq(16'hFFFF);
    run_seq(16'h0000);
    for (int i = 0; i < 4; i++) run_seq(16'($urandom));

    // Start held high: one sequence per 233 cycles, Xbus churning throughout.
    for (int i = 0; i < 500; i++) drive(1'b1, 16'($urandom));
    idle(240);

    // Random start pulses, most of them landing in MUL/DIV and ignored.
    for (int i = 0; i < 700; i++) drive($urandom_range(0, 3) == 0, 16'($urandom));
    idle(240);

    // Reset after the third Done: outputs clear at once, no further Done.
    drive(1'b1, 16'($urandom));
    while (cyc < last_k + 1 + 66 + 5) drive(1'b0, 16'($urandom));
    @(negedge clk);
    rst    = 1'b0;
    last_k = -1000;
    sb.delete();
    #1 check_outputs_zero("midreset");
    idle(40);
    @(negedge clk);
    rst = 1'b1;
    run_seq(16'($urandom));
    run_seq(16'h8000);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
